instr_fetch_unit: RTL and testbench

//   Hart-side instruction fetch stage. It sits directly upstream of MainModule's instruction port.
//   - Drives instr_valid / instr_size / instr_addr to the interconnect.
//   - Takes instructions back on instr_valid_to_hart / instr_out.
//   - Buffers fetched words with their PCs in a small prefetch FIFO feeding decode (valid/ready).
//   - Supports a branch/jump redirect that flushes the FIFO and any in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 86 ++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: hart fetch stage issuing word fetches to the interconnect and
// buffering returned instructions with their PCs in a prefetch FIFO toward decode.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            instr_valid,
  output logic [1:0]      instr_size,
  output logic [XLEN-1:0] instr_addr,
  input  logic            interc_ready,
  input  logic            instr_valid_to_hart,
  input  logic [XLEN-1:0] instr_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            discard_q, discard_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] mem_instr [FIFO_DEPTH];
  logic [XLEN-1:0] mem_pc    [FIFO_DEPTH];
  logic            accept, resp, push, pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wptr_q] <= instr_out;
      mem_pc[wptr_q]    <= pc_q;
    end
  end
  // the fetched word belongs to pc_q: pc only advances when its word is pushed
  always_comb begin
    accept    = state_q == REQ && interc_ready;
    resp      = state_q == WAIT && instr_valid_to_hart;
    push      = resp && !discard_q && !redirect_valid;
    pop       = if_valid && id_ready;
    cnt_d     = redirect_valid ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wptr_d    = redirect_valid ? '0 : wptr_q + AW'(push);
    rptr_d    = redirect_valid ? '0 : rptr_q + AW'(pop);
    pc_d      = redirect_valid ? redirect_pc : push ? pc_q + XLEN'(PC_STEP) : pc_q;
    discard_d = resp ? 1'b0 : (redirect_valid && (state_q == WAIT || accept)) ? 1'b1 : discard_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (redirect_valid || cnt_q < (AW+1)'(FIFO_DEPTH)) ? REQ : IDLE;
      REQ:     state_d = accept ? WAIT : REQ;
      WAIT:    state_d = !resp ? WAIT : cnt_d < (AW+1)'(FIFO_DEPTH) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    instr_valid = state_q == REQ;
    instr_size  = 2'd2;
    instr_addr  = pc_q;
    if_valid    = cnt_q != '0;
    if_instr    = if_valid ? mem_instr[rptr_q] : '0;
    if_pc       = if_valid ? mem_pc[rptr_q] : '0;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a small interconnect responder driving the fetch unit.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [1:0]  instr_size;
  logic [31:0] instr_addr;
  logic        interc_ready;
  logic        instr_valid_to_hart;
  logic [31:0] instr_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  int pass_n = 0, tot_n = 0;
  int lat, cnt;
  logic pend;
  logic [31:0] paddr;
  logic [31:0] acc_q[$], pop_q[$], pdat_q[$];
  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_size(instr_size),
    .instr_addr(instr_addr), .interc_ready(interc_ready),
    .instr_valid_to_hart(instr_valid_to_hart), .instr_out(instr_out),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  // runs at a negedge: retire the last response, count down, note what the next edge accepts/pops
  task automatic tick();
    if (instr_valid_to_hart) begin
      instr_valid_to_hart = 1'b0;
      pend = 1'b0;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        instr_valid_to_hart = 1'b1;
        instr_out = ~paddr;
      end
    end
    if (instr_valid && interc_ready) begin
      pend = 1'b1;
      cnt = lat;
      paddr = instr_addr;
      acc_q.push_back(instr_addr);
    end
    if (if_valid && id_ready) begin
      pop_q.push_back(if_pc);
      pdat_q.push_back(if_instr);
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    instr_valid_to_hart = 1'b0;
    pend = 1'b0;
    acc_q.delete();
    pop_q.delete();
    pdat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return q.size() > i ? q[i] : 32'hDEAD_BEEF;
  endfunction
  initial begin
    rst_n = 1'b0;
    interc_ready = 1'b1;
    id_ready = 1'b1;
    instr_valid_to_hart = 1'b0;
    instr_out = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    lat = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_size", 32'(instr_size), 2);
    chk("rst_addr", instr_addr, 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    // 1: streaming
    rst_n = 1'b1;
    tick();
    chk("t1_first_valid", 32'(instr_valid), 1);
    chk("t1_first_addr", instr_addr, 0);
    repeat (2) tick();
    chk("t1_if_valid", 32'(if_valid), 1);
    chk("t1_if_pc", if_pc, 0);
    repeat (14) tick();
    chk("t1_acc_n", acc_q.size(), 8);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_acc%0d", i), at(acc_q, i), 32'(4 * i));
    for (int i = 0; i < 4; i++) chk($sformatf("t1_pop%0d", i), at(pop_q, i), 32'(4 * i));
    chk("t1_pdat2", at(pdat_q, 2), 32'hFFFF_FFF7);
    // 2: decode stalled, FIFO fills
    id_ready = 1'b0;
    do_reset();
    repeat (20) tick();
    chk("t2_acc_n", acc_q.size(), 4);
    chk("t2_acc3", at(acc_q, 3), 12);
    chk("t2_valid", 32'(instr_valid), 0);
    chk("t2_if_valid", 32'(if_valid), 1);
    chk("t2_if_pc", if_pc, 0);
    chk("t2_if_instr", if_instr, 32'hFFFF_FFFF);
    id_ready = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() < 5; i++) tick();
    chk("t2_resume_n", acc_q.size(), 5);
    chk("t2_resume_addr", at(acc_q, 4), 16);
    // 3: interconnect back-pressure
    interc_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_hold_valid%0d", i), 32'(instr_valid), 1);
      chk($sformatf("t3_hold_addr%0d", i), instr_addr, 0);
    end
    chk("t3_no_acc", acc_q.size(), 0);
    interc_ready = 1'b1;
    tick();
    chk("t3_acc_n", acc_q.size(), 1);
    chk("t3_acc0", at(acc_q, 0), 0);
    // 4: redirect while waiting on a slow response
    lat = 3;
    do_reset();
    repeat (2) tick();
    chk("t4_in_wait", 32'(instr_valid), 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    chk("t4_req_addr", instr_addr, 32'h100);
    chk("t4_fifo_empty", 32'(if_valid), 0);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    chk("t4_if_pc", if_pc, 32'h100);
    chk("t4_if_instr", if_instr, 32'hFFFF_FEFF);
    // 5: redirect coinciding with a response and a dequeue
    lat = 1;
    id_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("t5_pre_if_pc", if_pc, 0);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t5_pop_n", pop_q.size(), 1);
    chk("t5_pop0", at(pop_q, 0), 0);
    chk("t5_empty", 32'(if_valid), 0);
    chk("t5_req_valid", 32'(instr_valid), 1);
    chk("t5_req_addr", instr_addr, 32'h200);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    chk("t5_if_pc", if_pc, 32'h200);
    // 6: async reset mid-WAIT
    do_reset();
    repeat (6) tick();
    chk("t6_wait_valid", 32'(instr_valid), 0);
    chk("t6_wait_addr", instr_addr, 8);
    rst_n = 1'b0;
    #1;
    chk("t6_async_addr", instr_addr, 0);
    chk("t6_async_if_valid", 32'(if_valid), 0);
    chk("t6_async_if_pc", if_pc, 0);
    do_reset();
    tick();
    chk("t6_restart_valid", 32'(instr_valid), 1);
    chk("t6_restart_addr", instr_addr, 0);
    // 7: PC wrap, entered by a redirect accepted on the same edge as the request
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    chk("t7_acc0", at(acc_q, 0), 0);
    chk("t7_acc1", at(acc_q, 1), 32'hFFFF_FFF8);
    chk("t7_acc2", at(acc_q, 2), 32'hFFFF_FFFC);
    chk("t7_acc3", at(acc_q, 3), 32'h0);
    chk("t7_pop0", at(pop_q, 0), 32'hFFFF_FFF8);
    chk("t7_pop2", at(pop_q, 2), 32'h0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
